buffer_uart_tx: RTL and testbench
=================================

BUFFER_UART_TX -- requirements
Module: buffer_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868, clock cycles per serial bit; legal range >= 2.
REQ-002 Parameter BUFFER_ADDR_SIZE, default 2, width of the source buffer occupancy count.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port tx_enable  input  1  permits starting a new frame; frames in flight are unaffected.
REQ-006 Port buffer_size_avai  input  BUFFER_ADDR_SIZE  occupancy count of the source byte buffer; nonzero means a byte is available.
REQ-007 Port buffer_data  input  8  head byte of the source buffer; valid whenever buffer_size_avai is nonzero.
REQ-008 Port buffer_read_en  output  1  one-cycle pop strobe to the source buffer.
REQ-009 Port tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-010 Port busy  output  1  high while a frame is in START, DATA or STOP.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-012 buffer_read_en SHALL be combinational: 1 iff state==IDLE and tx_enable==1 and buffer_size_avai!=0.
REQ-013 On the edge where buffer_read_en is 1: buffer_data latched into an 8-bit shift register, state -> START, baud counter cleared.
REQ-014 At most one pop per frame; buffer_read_en SHALL be 0 in START, DATA and STOP regardless of inputs.
REQ-015 tx SHALL be a registered output: 0 for exactly CLKS_PER_BIT cycles in START, data bits in DATA, 1 in STOP and IDLE.
REQ-016 First START cycle SHALL be the cycle immediately after the pop edge (latency 1 cycle from pop to tx falling).
REQ-017 Baud counter counts 0..CLKS_PER_BIT-1; on terminal count the bit period ends and the counter wraps to 0.
REQ-018 START -> DATA at terminal count; DATA shifts out bit0..bit7, 3-bit bit index wraps 7 -> 0 with DATA -> STOP.
REQ-019 STOP holds tx=1 for CLKS_PER_BIT cycles, then -> IDLE.
REQ-020 Back-to-back: with data pending, IDLE lasts exactly 1 cycle (the pop cycle), giving CLKS_PER_BIT+1 high cycles between frames.
REQ-021 Changes of buffer_size_avai, buffer_data or tx_enable during START/DATA/STOP SHALL NOT alter the frame in flight.
REQ-022 tx_enable low in IDLE: no pop, tx=1, busy=0, indefinitely.
REQ-023 busy SHALL be registered-state derived: 1 iff state != IDLE.

Reset
REQ-024 Asserting reset SHALL immediately set state=IDLE, tx=1, busy=0, baud counter=0, bit index=0, shift register=0x00.
REQ-025 Reset mid-frame SHALL abort the frame with no pop and no further tx low; the aborted byte is lost.
REQ-026 While reset is high, buffer_read_en SHALL be 0.
REQ-027 After reset deasserts, the first pop SHALL occur on the first edge meeting REQ-012.

Structure
REQ-028 Shared package SHALL hold the FSM state encoding (2-bit), the frame constants DATA_BITS=8 and STOP_BITS=1, and the idle line level.
REQ-029 Baud timing SHALL be a sub-module uart_baud_counter (clear input, terminal-count tick output, parameter CLKS_PER_BIT).
REQ-030 Top-level RTL SHALL contain only FSM, shift register, bit index and output logic.

Verification (CLKS_PER_BIT=4, source is a 4-entry byte buffer)
REQ-031 Single byte 0xA5, tx_enable=1 -> one pop; tx = 0 x4, then bits 1,0,1,0,0,1,0,1 x4 each, then 1 x4; busy high 40 cycles.
REQ-032 Three bytes 0x00,0xFF,0x55 preloaded -> three pops, frames in order, exactly 5 high cycles between each stop start and next start bit.
REQ-033 tx_enable=0 with buffer holding 2 bytes -> no pop for 100 cycles, tx=1; raise tx_enable -> pop on that cycle, start bit next cycle.
REQ-034 Reset asserted in DATA bit 3 of 0x3C -> tx=1 and busy=0 without waiting for a clock edge; no pop during reset; next byte after release transmits intact.
REQ-035 buffer_size_avai and buffer_data toggled randomly mid-frame -> transmitted byte equals the value latched at pop, buffer_read_en stays 0.
REQ-036 Empty buffer after reset -> buffer_read_en never asserts, tx constant 1 for 200 cycles.

Source files
------------

// File: rtl/buffer_uart_tx_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding and frame constants.
package buffer_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned STOP_BITS  = 1;
  localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/buffer_uart_tx_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_comb tick = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/buffer_uart_tx.sv
// 8N1 UART transmitter that pops bytes from an external buffer, one pop per frame.
module buffer_uart_tx
  import buffer_uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT     = 868,
  parameter int unsigned BUFFER_ADDR_SIZE = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tx_enable,
  input  logic [BUFFER_ADDR_SIZE-1:0] buffer_size_avai,
  input  logic [7:0]                  buffer_data,
  output logic                        buffer_read_en,
  output logic                        tx,
  output logic                        busy
);

  tx_state_e  state;
  logic [7:0] shift_reg;
  logic [2:0] bit_idx;
  logic       baud_tick;

  // Gated by reset so no pop can be issued while the block is held in reset.
  always_comb begin
    buffer_read_en = !reset && (state == IDLE) && tx_enable && (buffer_size_avai != '0);
  end

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (buffer_read_en),
    .tick  (baud_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= IDLE_LEVEL;
      busy      <= 1'b0;
      shift_reg <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (buffer_read_en) begin
            shift_reg <= buffer_data;
            state     <= START;
            tx        <= ~IDLE_LEVEL;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (baud_tick) begin
            state <= DATA;
            tx    <= shift_reg[0];
          end
        end
        DATA: begin
          if (baud_tick) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
              tx    <= IDLE_LEVEL;
            end else begin
              // Next bit is driven from the pre-shift value to keep tx registered.
              shift_reg <= {1'b0, shift_reg[7:1]};
              tx        <= shift_reg[1];
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_uart_tx.sv
// Directed self-checking bench for buffer_uart_tx with a 4-entry byte buffer model.
module tb_buffer_uart_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned AW  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          tx_enable;
  logic [AW-1:0] buffer_size_avai;
  logic [7:0]    buffer_data;
  logic          buffer_read_en;
  logic          tx;
  logic          busy;

  logic [7:0] q[$];
  int         pops = 0;
  bit         scramble = 0;
  int         tests = 0;
  int         failed = 0;

  buffer_uart_tx #(
    .CLKS_PER_BIT     (CPB),
    .BUFFER_ADDR_SIZE (AW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .tx_enable        (tx_enable),
    .buffer_size_avai (buffer_size_avai),
    .buffer_data      (buffer_data),
    .buffer_read_en   (buffer_read_en),
    .tx               (tx),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    if (!scramble) begin
      buffer_size_avai = AW'(q.size());
      buffer_data      = (q.size() > 0) ? q[0] : 8'h00;
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    refresh();
  endtask

  // Source buffer: pop on every edge where the strobe was high.
  always @(posedge clk) begin
    logic rd_s;
    rd_s = buffer_read_en;
    #1;
    if (rd_s) begin
      pops++;
      if (q.size() > 0) void'(q.pop_front());
    end
    refresh();
  end

  always @(negedge clk) begin
    if (scramble) begin
      buffer_size_avai = AW'($urandom);
      buffer_data      = 8'($urandom);
    end
  end

  task automatic wait_start(input string tag, output int sk);
    bit found;
    found = 0;
    sk = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1;
      else sk++;
    end
    check({tag, "_start_seen"}, 32'(found), 32'd1);
  endtask

  // Entry point is the negedge holding the first start-bit sample.
  task automatic expect_frame(input logic [7:0] b, input string tag);
    logic [3:0] s;
    logic [3:0] exp;
    int bz;
    bz = 0;
    for (int n = 0; n < 10; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!(n == 0 && k == 0)) @(negedge clk);
        s[k] = tx;
        if (busy === 1'b1) bz++;
      end
      if (n == 0)      exp = 4'h0;
      else if (n == 9) exp = 4'hF;
      else             exp = {4{b[n-1]}};
      check($sformatf("%s_bit%0d", tag, n), 32'(s), 32'(exp));
    end
    check({tag, "_busy_cycles"}, 32'(bz), 32'd40);
  endtask

  initial begin
    int sk, p0, lows, rds;
    reset = 1'b1;
    tx_enable = 1'b0;
    refresh();
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(buffer_read_en), 32'd0);
    reset = 1'b0;
    tx_enable = 1'b1;

    // Empty buffer: line stays idle, no pops.
    lows = 0; rds = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (buffer_read_en !== 1'b0) rds++;
    end
    check("empty_tx_low", 32'(lows), 32'd0);
    check("empty_rd_en", 32'(rds), 32'd0);
    check("empty_pops", 32'(pops), 32'd0);

    // Single byte 0xA5.
    p0 = pops;
    push(8'hA5);
    wait_start("a5", sk);
    expect_frame(8'hA5, "a5");
    @(negedge clk);
    check("a5_busy_after", 32'(busy), 32'd0);
    check("a5_pops", 32'(pops - p0), 32'd1);

    // Back-to-back three bytes.
    repeat (3) @(negedge clk);
    p0 = pops;
    push(8'h00); push(8'hFF); push(8'h55);
    wait_start("b0", sk);
    expect_frame(8'h00, "b0");
    wait_start("b1", sk);
    check("gap1", 32'(4 + sk), 32'd5);
    expect_frame(8'hFF, "b1");
    wait_start("b2", sk);
    check("gap2", 32'(4 + sk), 32'd5);
    expect_frame(8'h55, "b2");
    check("b2b_pops", 32'(pops - p0), 32'd3);

    // tx_enable low holds off transmission.
    repeat (3) @(negedge clk);
    tx_enable = 1'b0;
    p0 = pops;
    push(8'h81); push(8'h7E);
    lows = 0; rds = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (buffer_read_en !== 1'b0) rds++;
    end
    check("hold_tx_low", 32'(lows), 32'd0);
    check("hold_rd_en", 32'(rds), 32'd0);
    check("hold_busy", 32'(busy), 32'd0);
    tx_enable = 1'b1;
    #1;
    check("en_rd_now", 32'(buffer_read_en), 32'd1);
    wait_start("en0", sk);
    check("en_latency", 32'(sk), 32'd0);
    expect_frame(8'h81, "en0");
    wait_start("en1", sk);
    expect_frame(8'h7E, "en1");
    check("en_pops", 32'(pops - p0), 32'd2);

    // Reset during data bit 3 of 0x3C.
    repeat (3) @(negedge clk);
    push(8'h3C); push(8'hC3);
    wait_start("rs", sk);
    repeat (17) @(negedge clk);
    check("rs_pre_bit3", 32'(tx), 32'd1);
    reset = 1'b1;
    #1;
    check("rs_tx", 32'(tx), 32'd1);
    check("rs_busy", 32'(busy), 32'd0);
    check("rs_rd_en", 32'(buffer_read_en), 32'd0);
    p0 = pops; rds = 0;
    repeat (5) begin
      @(negedge clk);
      if (buffer_read_en !== 1'b0) rds++;
    end
    check("rs_hold_rd", 32'(rds), 32'd0);
    check("rs_hold_pops", 32'(pops - p0), 32'd0);
    check("rs_queue", 32'(q.size()), 32'd1);
    reset = 1'b0;
    wait_start("rs_next", sk);
    expect_frame(8'hC3, "rs_next");

    // Inputs scrambled mid-frame must not disturb the latched byte.
    repeat (3) @(negedge clk);
    p0 = pops;
    push(8'h96);
    wait_start("sc", sk);
    scramble = 1;
    expect_frame(8'h96, "sc");
    scramble = 0;
    #1;
    refresh();
    check("sc_pops", 32'(pops - p0), 32'd1);
    repeat (5) @(negedge clk);
    check("sc_idle_tx", 32'(tx), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
